// File: rtl/regfile_pkg.sv
// Shared register-file writeback definitions: widths, register count and the queued write entry.
package regfile_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int REG_ZERO = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small power-of-two FIFO holding pending register writes for one writeback requester.
// Besides push/pop it exports a one-hot-OR vector of the destination registers currently queued.
module wb_fifo #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int DATA_W = regfile_pkg::DATA_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [ADDR_W-1:0]    push_rd,
  input  logic [DATA_W-1:0]    push_data,
  input  logic                 pop,
  output logic                 full,
  output logic                 empty,
  output logic [ADDR_W-1:0]    head_rd,
  output logic [DATA_W-1:0]    head_data,
  output logic [2**ADDR_W-1:0] rd_vec
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] mem_rd   [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              do_push;
  logic              do_pop;

  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_rd   = mem_rd[rd_ptr];
  assign head_data = mem_data[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_rd[wr_ptr]   <= push_rd;
      mem_data[wr_ptr] <= push_data;
    end
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    rd_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ({1'b0, PTR_W'(PTR_W'(i) - rd_ptr)} < count) begin
        rd_vec[mem_rd[i]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin sharing of the register-file write port between load (port 0) and ALU (port 1) writeback.
// Optional statistics counters are compiled in with WB_STATS_EN.
module regfile_wb_arbiter #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wb0_valid,
  output logic                 wb0_ready,
  input  logic [ADDR_W-1:0]    wb0_rd,
  input  logic [DATA_W-1:0]    wb0_data,
  input  logic                 wb1_valid,
  output logic                 wb1_ready,
  input  logic [ADDR_W-1:0]    wb1_rd,
  input  logic [DATA_W-1:0]    wb1_data,
  output logic                 Reg_write,
  output logic [ADDR_W-1:0]    Write_reg,
  output logic [DATA_W-1:0]    Write_data,
  output logic [2**ADDR_W-1:0] busy_mask
`ifdef WB_STATS_EN
  ,
  output logic [15:0]          stall_cnt0,
  output logic [15:0]          stall_cnt1,
  output logic [15:0]          drop_cnt
`endif
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic                full0, full1, empty0, empty1;
  logic [ADDR_W-1:0]   head_rd0, head_rd1;
  logic [DATA_W-1:0]   head_data0, head_data1;
  logic [NUM_REGS-1:0] vec0, vec1, out_vec;
  logic                grant0, grant1, pop_any;
  logic [ADDR_W-1:0]   pop_rd;
  logic [DATA_W-1:0]   pop_data;
  logic                pop_is_zero;
  logic                rr_last;

  // Readiness comes from registered occupancy only, so there is no pass-through path.
  assign wb0_ready = !full0;
  assign wb1_ready = !full1;

  wb_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fifo0 (
    .clk(clk), .reset(reset),
    .push(wb0_valid), .push_rd(wb0_rd), .push_data(wb0_data),
    .pop(grant0), .full(full0), .empty(empty0),
    .head_rd(head_rd0), .head_data(head_data0), .rd_vec(vec0)
  );

  wb_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fifo1 (
    .clk(clk), .reset(reset),
    .push(wb1_valid), .push_rd(wb1_rd), .push_data(wb1_data),
    .pop(grant1), .full(full1), .empty(empty1),
    .head_rd(head_rd1), .head_data(head_data1), .rd_vec(vec1)
  );

  // Under contention the port that did not win last time gets the slot.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!empty0 && !empty1) begin
      if (rr_last) grant0 = 1'b1;
      else         grant1 = 1'b1;
    end else if (!empty0) begin
      grant0 = 1'b1;
    end else if (!empty1) begin
      grant1 = 1'b1;
    end
  end

  assign pop_any     = grant0 || grant1;
  assign pop_rd      = grant0 ? head_rd0 : head_rd1;
  assign pop_data    = grant0 ? head_data0 : head_data1;
  assign pop_is_zero = (pop_rd == ADDR_W'(regfile_pkg::REG_ZERO));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_last <= 1'b1;
    end else if (!empty0 && !empty1) begin
      rr_last <= grant1;
    end
  end

  // Writes to x0 still consume a slot but never raise the write enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Reg_write  <= 1'b0;
      Write_reg  <= '0;
      Write_data <= '0;
    end else begin
      Reg_write <= pop_any && !pop_is_zero;
      if (pop_any) begin
        Write_reg  <= pop_rd;
        Write_data <= pop_data;
      end
    end
  end

  always_comb begin
    out_vec = '0;
    if (Reg_write) out_vec[Write_reg] = 1'b1;
    busy_mask = (vec0 | vec1 | out_vec) & ~NUM_REGS'(1);
  end

`ifdef WB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt0 <= '0;
      stall_cnt1 <= '0;
      drop_cnt   <= '0;
    end else begin
      if (wb0_valid && !wb0_ready && stall_cnt0 != 16'hFFFF) stall_cnt0 <= stall_cnt0 + 16'd1;
      if (wb1_valid && !wb1_ready && stall_cnt1 != 16'hFFFF) stall_cnt1 <= stall_cnt1 + 16'd1;
      if (pop_any && pop_is_zero && drop_cnt != 16'hFFFF)    drop_cnt   <= drop_cnt + 16'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  // The issue stage must never let the same nonzero register be queued on both ports.
  a_no_cross_port_dup : assert property (@(posedge clk) disable iff (reset)
    ((vec0 & vec1) & ~NUM_REGS'(1)) == '0)
    else $error("regfile_wb_arbiter: register pending in both writeback FIFOs");
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized scoreboard bench for regfile_wb_arbiter against a queue-level reference model.
module tb_regfile_wb_arbiter;

  localparam int DEPTH  = 2;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              wb0_valid = 1'b0, wb1_valid = 1'b0;
  logic              wb0_ready, wb1_ready;
  logic [ADDR_W-1:0] wb0_rd = '0, wb1_rd = '0;
  logic [DATA_W-1:0] wb0_data = '0, wb1_data = '0;
  logic              Reg_write;
  logic [ADDR_W-1:0] Write_reg;
  logic [DATA_W-1:0] Write_data;
  logic [31:0]       busy_mask;
`ifdef WB_STATS_EN
  logic [15:0]       stall_cnt0, stall_cnt1, drop_cnt;
`endif

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_rd(wb0_rd), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_rd(wb1_rd), .wb1_data(wb1_data),
    .Reg_write(Reg_write), .Write_reg(Write_reg), .Write_data(Write_data),
    .busy_mask(busy_mask)
`ifdef WB_STATS_EN
    , .stall_cnt0(stall_cnt0), .stall_cnt1(stall_cnt1), .drop_cnt(drop_cnt)
`endif
  );

  typedef struct {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } beat_t;

  typedef struct {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;

  beat_t pend0[$], pend1[$], q0[$], q1[$];
  exp_t  exp_q[$];
  exp_t  mon_e;
  bit    vld0, vld1;
  bit    rr_last_m = 1'b1;
  bit    out_busy_m;
  logic [ADDR_W-1:0] out_rd_m;
  int    edge_cnt, vectors, miscompares;
  int    stall0_m, stall1_m, drop_m;

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  function automatic logic [31:0] modelMask();
    logic [31:0] m = '0;
    foreach (q0[i]) m[q0[i].rd] = 1'b1;
    foreach (q1[i]) m[q1[i].rd] = 1'b1;
    if (out_busy_m) m[out_rd_m] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  // One clock edge of the reference: arbitrate over queue heads, then accept new beats.
  task automatic modelEdge(input bit acc0, input bit acc1);
    int    win = -1;
    beat_t b;
    if (q0.size() > 0 && q1.size() > 0) begin
      win = rr_last_m ? 0 : 1;
      rr_last_m = (win == 1);
    end else if (q0.size() > 0) win = 0;
    else if (q1.size() > 0)     win = 1;
    out_busy_m = 1'b0;
    if (win >= 0) begin
      b = (win == 0) ? q0.pop_front() : q1.pop_front();
      if (b.rd == 0) drop_m++;
      else begin
        exp_q.push_back('{rd: b.rd, data: b.data, cyc: edge_cnt});
        out_busy_m = 1'b1;
        out_rd_m   = b.rd;
      end
    end
    if (acc0) q0.push_back(pend0[0]);
    if (acc1) q1.push_back(pend1[0]);
  endtask

  task automatic stepCycle(input int gap_pct);
    bit acc0, acc1;
    if (!vld0 && pend0.size() > 0 && $urandom_range(0, 99) >= gap_pct) vld0 = 1'b1;
    if (!vld1 && pend1.size() > 0 && $urandom_range(0, 99) >= gap_pct) vld1 = 1'b1;
    wb0_valid = vld0;
    wb1_valid = vld1;
    if (vld0) begin wb0_rd = pend0[0].rd; wb0_data = pend0[0].data; end
    if (vld1) begin wb1_rd = pend1[0].rd; wb1_data = pend1[0].data; end
    checkOutput("wb0_ready", 64'(wb0_ready), 64'(q0.size() < DEPTH));
    checkOutput("wb1_ready", 64'(wb1_ready), 64'(q1.size() < DEPTH));
    checkOutput("busy_mask", 64'(busy_mask), 64'(modelMask()));
    acc0 = vld0 && (q0.size() < DEPTH);
    acc1 = vld1 && (q1.size() < DEPTH);
    if (vld0 && !acc0) stall0_m++;
    if (vld1 && !acc1) stall1_m++;
    @(posedge clk);
    edge_cnt++;
    modelEdge(acc0, acc1);
    if (acc0) begin void'(pend0.pop_front()); vld0 = 1'b0; end
    if (acc1) begin void'(pend1.pop_front()); vld1 = 1'b0; end
    @(negedge clk);
  endtask

  task automatic applyStimulus(input int gap_pct, input int budget);
    int n = 0;
    while ((pend0.size() > 0 || pend1.size() > 0) && n < budget) begin
      stepCycle(gap_pct);
      n++;
    end
    if (pend0.size() > 0 || pend1.size() > 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL stimulus_timeout: %0d beats still pending, expected 0",
               pend0.size() + pend1.size());
      pend0.delete(); pend1.delete();
      vld0 = 1'b0; vld1 = 1'b0;
    end
    repeat (2 * DEPTH + 4) stepCycle(gap_pct);
  endtask

  // Scoreboard monitor: every observed register write must match the next expected one, on time.
  always @(negedge clk) begin
    if (!reset) begin
      if (Reg_write) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_write: got rd=%0d data=%h, expected no write", Write_reg, Write_data);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("write_rd", 64'(Write_reg), 64'(mon_e.rd));
          checkOutput("write_data", 64'(Write_data), 64'(mon_e.data));
          checkOutput("write_cycle", 64'(edge_cnt), 64'(mon_e.cyc));
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= edge_cnt) begin
        mon_e = exp_q.pop_front();
        vectors++;
        miscompares++;
        $display("[TB] FAIL missing_write: got Reg_write=0, expected rd=%0d data=%h", mon_e.rd, mon_e.data);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("rst_reg_write", 64'(Reg_write), 64'd0);
    checkOutput("rst_busy_mask", 64'(busy_mask), 64'd0);
    checkOutput("rst_write_reg", 64'(Write_reg), 64'd0);
    reset = 1'b0;
    #1;
    checkOutput("idle_wb0_ready", 64'(wb0_ready), 64'd1);
    checkOutput("idle_wb1_ready", 64'(wb1_ready), 64'd1);
    @(negedge clk);

    $display("[TB] single write on port 1");
    pend1.push_back('{rd: 5'd5, data: 32'hDEADBEEF});
    applyStimulus(0, 50);

    $display("[TB] contention");
    for (int i = 1; i <= 4; i++) begin
      pend0.push_back('{rd: 5'(i), data: $urandom});
      pend1.push_back('{rd: 5'(10 + i), data: $urandom});
    end
    applyStimulus(0, 100);

    $display("[TB] backpressure");
    for (int i = 1; i <= 5; i++) pend0.push_back('{rd: 5'(i), data: $urandom});
    for (int i = 16; i < 28; i++) pend1.push_back('{rd: 5'(i), data: $urandom});
    applyStimulus(0, 200);

    $display("[TB] x0 drop");
    pend0.push_back('{rd: 5'd0, data: 32'h1234});
    applyStimulus(0, 50);
`ifdef WB_STATS_EN
    checkOutput("drop_cnt_x0", 64'(drop_cnt), 64'(drop_m));
`endif

    $display("[TB] wrap-around");
    for (int i = 1; i <= 10; i++) pend0.push_back('{rd: 5'(i), data: $urandom});
    applyStimulus(0, 100);

    $display("[TB] random traffic");
    for (int k = 0; k < 60; k++) begin
      pend0.push_back('{rd: 5'($urandom_range(0, 15)), data: $urandom});
      pend1.push_back('{rd: ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(16, 31)), data: $urandom});
    end
    applyStimulus(30, 3000);
`ifdef WB_STATS_EN
    checkOutput("stall_cnt0", 64'(stall_cnt0), 64'(stall0_m));
    checkOutput("stall_cnt1", 64'(stall_cnt1), 64'(stall1_m));
    checkOutput("drop_cnt", 64'(drop_cnt), 64'(drop_m));
`endif

    $display("[TB] reset mid-stream");
    pend0.push_back('{rd: 5'd3, data: 32'hA0A0A0A0});
    pend0.push_back('{rd: 5'd4, data: 32'hB0B0B0B0});
    pend1.push_back('{rd: 5'd20, data: 32'hC0C0C0C0});
    pend1.push_back('{rd: 5'd21, data: 32'hD0D0D0D0});
    stepCycle(0);
    stepCycle(0);
    reset = 1'b1;
    #1;
    checkOutput("midrst_reg_write", 64'(Reg_write), 64'd0);
    checkOutput("midrst_write_reg", 64'(Write_reg), 64'd0);
    checkOutput("midrst_write_data", 64'(Write_data), 64'd0);
    checkOutput("midrst_busy_mask", 64'(busy_mask), 64'd0);
    checkOutput("midrst_wb0_ready", 64'(wb0_ready), 64'd1);
    pend0.delete(); pend1.delete(); q0.delete(); q1.delete(); exp_q.delete();
    vld0 = 1'b0; vld1 = 1'b0;
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    rr_last_m = 1'b1; out_busy_m = 1'b0;
    stall0_m = 0; stall1_m = 0; drop_m = 0;
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(0, 10);
    pend0.push_back('{rd: 5'd7, data: 32'h0BADF00D});
    applyStimulus(0, 50);
`ifdef WB_STATS_EN
    checkOutput("post_rst_drop_cnt", 64'(drop_cnt), 64'(drop_m));
`endif

    checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
